cache_line_refill: RTL

- Controller for one CacheLine storage instance. It drives the line's write port and consumes its read port.
- On a miss request it writes a dirty victim line back to memory word by word, then refills the line from memory.
- On a flush request it writes back a dirty line and then clears its dirty bit.
- Sits between the cache lookup logic (request side) and the word-wide memory bus (memory side).

---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_line_refill.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache line refill controller:
// FSM state encoding, line geometry derivation and memory address composition.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB_SETUP = 3'd1,
    WB_REQ   = 3'd2,
    FILL     = 3'd3,
    CLEAN    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // Width of the word offset within a line (line bytes -> 32-bit words).
  function automatic int calc_off_w(input int line_width);
    return line_width - 2;
  endfunction

  // Number of 32-bit words per line.
  function automatic int calc_words(input int line_width);
    return 1 << (line_width - 2);
  endfunction

  // Byte address {tag, index, word, 2'b00}; fields arrive zero-extended.
  function automatic logic [31:0] compose_addr(input logic [31:0] tag,
                                               input logic [31:0] index,
                                               input logic [31:0] word,
                                               input int index_width,
                                               input int line_width);
    return (tag << (index_width + line_width)) | (index << line_width) | (word << 2);
  endfunction

endpackage

// File: rtl/cache_line_refill.sv
// Writeback/refill controller for a single cache line: writes a dirty victim
// back word by word, then refills from memory (miss) or clears dirty (flush).
module cache_line_refill
  import cache_pkg::*;
#(
  parameter  int CACHE_LINE_WIDTH = 6,
  parameter  int TAG_WIDTH        = 20,
  parameter  int INDEX_WIDTH      = 6,
  localparam int OFF_W            = calc_off_w(CACHE_LINE_WIDTH)
) (
  input  logic                   nrst,
  input  logic                   clk,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_flush,
  input  logic [TAG_WIDTH-1:0]   req_tag,
  input  logic [INDEX_WIDTH-1:0] req_index,
  output logic                   done,
  input  logic [TAG_WIDTH-1:0]   line_rd_tag,
  output logic [OFF_W-1:0]       line_rd_off,
  input  logic [31:0]            line_rd_data,
  input  logic                   line_rd_dirty,
  input  logic                   line_rd_valid,
  output logic                   line_wr_write,
  output logic [TAG_WIDTH-1:0]   line_wr_tag,
  output logic [OFF_W-1:0]       line_wr_off,
  output logic [31:0]            line_wr_data,
  output logic [3:0]             line_wr_byte_enable,
  output logic                   line_wr_dirty,
  output logic                   line_wr_valid,
  output logic [31:0]            mem_addr,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack
);

  localparam int               N    = calc_words(CACHE_LINE_WIDTH);
  localparam logic [OFF_W-1:0] LAST = OFF_W'(N - 1);

  if (TAG_WIDTH + INDEX_WIDTH + CACHE_LINE_WIDTH != 32) begin : g_width_check
    $error("cache_line_refill: TAG_WIDTH + INDEX_WIDTH + CACHE_LINE_WIDTH must equal 32");
  end

  state_e                 state_q, state_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   flush_q, flush_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [TAG_WIDTH-1:0]   victim_q, victim_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;

  logic [31:0] victim_addr;
  logic [31:0] refill_addr;

  assign victim_addr = compose_addr(32'(victim_q), 32'(index_q), 32'(cnt_q),
                                    INDEX_WIDTH, CACHE_LINE_WIDTH);
  assign refill_addr = compose_addr(32'(tag_q), 32'(index_q), 32'(cnt_q),
                                    INDEX_WIDTH, CACHE_LINE_WIDTH);

  // State, word counter and request capture registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      flush_q  <= 1'b0;
      tag_q    <= '0;
      victim_q <= '0;
      index_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flush_q  <= flush_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
      index_q  <= index_d;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    flush_d             = flush_q;
    tag_d               = tag_q;
    victim_d            = victim_q;
    index_d             = index_q;
    req_ready           = 1'b0;
    done                = 1'b0;
    line_rd_off         = '0;
    line_wr_write       = 1'b0;
    line_wr_tag         = '0;
    line_wr_off         = '0;
    line_wr_data        = 32'h0000_0000;
    line_wr_byte_enable = 4'b0000;
    line_wr_dirty       = 1'b0;
    line_wr_valid       = 1'b0;
    mem_addr            = 32'h0000_0000;
    mem_rd              = 1'b0;
    mem_wr              = 1'b0;
    mem_wdata           = 32'h0000_0000;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          flush_d  = req_flush;
          tag_d    = req_tag;
          index_d  = req_index;
          victim_d = line_rd_tag;
          cnt_d    = '0;
          if (line_rd_valid && line_rd_dirty) begin
            state_d = WB_SETUP;
          end else if (!req_flush) begin
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WB_SETUP: begin
        line_rd_off = cnt_q;
        state_d     = WB_REQ;
      end

      WB_REQ: begin
        // Offset stays put so the registered read data remains valid until ack.
        line_rd_off = cnt_q;
        mem_wr      = 1'b1;
        mem_addr    = victim_addr;
        mem_wdata   = line_rd_data;
        if (mem_ack) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = flush_q ? CLEAN : FILL;
          end else begin
            cnt_d   = cnt_q + OFF_W'(1);
            state_d = WB_SETUP;
          end
        end else begin
          state_d = WB_REQ;
        end
      end

      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = refill_addr;
        if (mem_ack) begin
          line_wr_write       = 1'b1;
          line_wr_off         = cnt_q;
          line_wr_data        = mem_rdata;
          line_wr_byte_enable = 4'b1111;
          line_wr_tag         = tag_q;
          line_wr_dirty       = 1'b0;
          line_wr_valid       = (cnt_q == LAST);
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + OFF_W'(1);
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end

      CLEAN: begin
        line_wr_write       = 1'b1;
        line_wr_byte_enable = 4'b0000;
        line_wr_tag         = victim_q;
        line_wr_dirty       = 1'b0;
        line_wr_valid       = 1'b1;
        state_d             = DONE;
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
